// File: rtl/uart_tx_shifter_pkg.sv
// uart_tx_shifter_pkg
//   Definitions shared by the UART transmit path. The receive-side block is
//   expected to import this package as well.
//   - tx_state_e    : frame sequencer states (encodings are fixed)
//   - TX_IDLE_LEVEL : level of the serial line between frames
//   - STOP_CNT_W    : width of the stop-bit counter (1 or 2 stop bits)
//   - max_int       : elaboration-time helper
package uart_tx_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam int   STOP_CNT_W    = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_shifter_bit_timer.sv
// uart_bit_timer
//   Serial bit-time counter. Counts 0..DIVISOR-1 and wraps; Tick is high for
//   the single cycle in which the count sits at DIVISOR-1, i.e. the edge that
//   ends a bit time.
//   Ports:
//     Clk       : system clock
//     Clear_bar : asynchronous active-low clear
//     Restart   : synchronous restart; holds the count at 0 while high
//     Tick      : one-cycle pulse at the wrap
module uart_bit_timer #(
  parameter int DIVISOR = 16
) (
  input  logic Clk,
  input  logic Clear_bar,
  input  logic Restart,
  output logic Tick
);

  localparam int TW = $clog2(DIVISOR);

  logic [TW-1:0] count_q, count_d;
  logic          at_wrap;

  assign at_wrap = (count_q == TW'(DIVISOR - 1));
  assign Tick    = at_wrap && !Restart;

  always_comb begin
    count_d = count_q;
    if (Restart) begin
      count_d = '0;
    end else if (at_wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter
//   Transmit-side parallel-to-serial converter. A byte written with Load_bar
//   low lands in a one-entry holding register, is moved into the shifter and
//   sent LSB-first as start bit, WIDTH data bits and STOP_BITS stop bits.
//   Ports:
//     Clk       : system clock, rising edge
//     Clear_bar : asynchronous active-low reset
//     Load_bar  : active-low write strobe, sampled on the rising edge
//     D         : parallel data to transmit
//     Tx        : serial line, idles high
//     Thre      : holding register empty
//     Busy      : a frame is on the line
//     Overrun   : one-cycle pulse when a write is discarded
//   DELAY_RISE / DELAY_FALL are expressed in Clk cycles and applied to every
//   output; 0/0 gives plain registered outputs.
module uart_tx_shifter
  import uart_tx_shifter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIVISOR    = 16,
  parameter int STOP_BITS  = 1,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic [WIDTH-1:0] D,
  output logic             Tx,
  output logic             Thre,
  output logic             Busy,
  output logic             Overrun
);

  localparam int IW = $clog2(WIDTH) + 1;

  tx_state_e             state_q, state_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [STOP_CNT_W-1:0] stop_cnt_q, stop_cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic tick;
  logic last_bit;
  logic last_stop;
  logic transfer;
  logic load_req;

  // Timer is held at 0 while idle, so leaving IDLE always starts a fresh bit
  // time; back-to-back frames reuse the natural wrap at the end of STOP.
  uart_bit_timer #(
    .DIVISOR (DIVISOR)
  ) u_bit_timer (
    .Clk       (Clk),
    .Clear_bar (Clear_bar),
    .Restart   (state_q == IDLE),
    .Tick      (tick)
  );

  assign load_req  = !Load_bar;
  assign last_bit  = (bit_idx_q == IW'(WIDTH - 1));
  assign last_stop = (stop_cnt_q == STOP_CNT_W'(STOP_BITS - 1));
  // Hold empties into the shifter either straight from idle or on the very
  // last cycle of the final stop bit (no idle gap between frames).
  assign transfer  = hold_full_q &&
                     ((state_q == IDLE) ||
                      ((state_q == STOP) && tick && last_stop));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d = START;
          shift_d = hold_q;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (last_bit) begin
            state_d    = STOP;
            stop_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (last_stop) begin
            if (transfer) begin
              state_d = START;
              shift_d = hold_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A write is accepted if the hold slot is free now or is being vacated
    // on this same edge; otherwise it is dropped and flagged.
    if (load_req && (!hold_full_q || transfer)) begin
      hold_d      = D;
      hold_full_d = 1'b1;
    end else if (load_req) begin
      overrun_d = 1'b1;
    end else if (transfer) begin
      hold_full_d = 1'b0;
    end

    // Line level is computed from the next state so Tx changes on the same
    // edge as the state and comes straight from a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = TX_IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= '0;
      tx_q        <= TX_IDLE_LEVEL;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output rise/fall delay, in Clk cycles. Bit order: {Overrun, Busy, Thre, Tx}
  // ---------------------------------------------------------------------
  localparam int       DMAX    = max_int(DELAY_RISE, DELAY_FALL);
  localparam logic [3:0] OUT_RST = {1'b0, 1'b0, 1'b1, TX_IDLE_LEVEL};

  logic [3:0] out_raw;
  logic [3:0] out_dly;

  assign out_raw = {overrun_q, busy_q, !hold_full_q, tx_q};

  if (DMAX == 0) begin : g_no_delay
    assign out_dly = out_raw;
  end else begin : g_delay
    localparam int DW = $clog2(DMAX + 1);
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
      logic          level_q, level_d;
      logic [DW-1:0] cnt_q, cnt_d;

      // The output follows a new level once it has been pending for the
      // configured number of cycles; a delay of 0 on one edge behaves as 1
      // when the other edge needs the delay stage.
      always_comb begin
        int need;
        level_d = level_q;
        cnt_d   = cnt_q;
        need    = out_raw[gi] ? DELAY_RISE : DELAY_FALL;
        if (out_raw[gi] == level_q) begin
          cnt_d = '0;
        end else if (int'(cnt_q) + 1 >= need) begin
          level_d = out_raw[gi];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
          level_q <= OUT_RST[gi];
          cnt_q   <= '0;
        end else begin
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign out_dly[gi] = level_q;
    end
  end

  assign Tx      = out_dly[0];
  assign Thre    = out_dly[1];
  assign Busy    = out_dly[2];
  assign Overrun = out_dly[3];

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Bench for uart_tx_shifter. Two instances: A (DIVISOR=4, 1 stop bit) and
// B (DIVISOR=3, 2 stop bits). The reference model keeps a queue of expected
// line levels, one entry per clock, appended a whole frame at a time.
module tb_uart_tx_shifter;

  logic       clk = 1'b0;
  logic       clear_bar;
  logic [1:0] load_bar;
  logic [7:0] d_in;
  logic [1:0] tx, thre, busy, ovr;

  always #5 clk = ~clk;

  uart_tx_shifter #(
    .WIDTH(8), .DIVISOR(4), .STOP_BITS(1), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut_a (
    .Clk(clk), .Clear_bar(clear_bar), .Load_bar(load_bar[0]), .D(d_in),
    .Tx(tx[0]), .Thre(thre[0]), .Busy(busy[0]), .Overrun(ovr[0])
  );

  uart_tx_shifter #(
    .WIDTH(8), .DIVISOR(3), .STOP_BITS(2), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut_b (
    .Clk(clk), .Clear_bar(clear_bar), .Load_bar(load_bar[1]), .D(d_in),
    .Tx(tx[1]), .Thre(thre[1]), .Busy(busy[1]), .Overrun(ovr[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int       sel = 0;
  int       cycle = 0;
  bit       line[$];
  bit       hold_v = 1'b0;
  bit [7:0] hold_val = 8'h00;
  bit       exp_ovr = 1'b0;
  bit       last_acc = 1'b0;

  function automatic int div_of();
    return (sel == 0) ? 4 : 3;
  endfunction

  function automatic int stop_of();
    return (sel == 0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    line.delete();
    hold_v  = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input bit [7:0] d);
    bit xfer;
    bit acc;
    if (line.size() > 0) void'(line.pop_front());
    xfer = hold_v && (line.size() == 0);
    acc  = ld && (!hold_v || xfer);
    exp_ovr  = ld && !acc;
    last_acc = acc;
    if (xfer) begin
      for (int i = 0; i < div_of(); i++) line.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int i = 0; i < div_of(); i++) line.push_back(hold_val[b]);
      for (int i = 0; i < stop_of() * div_of(); i++) line.push_back(1'b1);
    end
    if (acc) begin
      hold_v   = 1'b1;
      hold_val = d;
    end else if (xfer) begin
      hold_v = 1'b0;
    end
    if (ld) $display("cycle %0d dut%0d load %02h %s", cycle, sel, d,
                     acc ? "accepted" : "dropped");
  endtask

  task automatic check_outputs();
    logic exp_tx;
    exp_tx = (line.size() > 0) ? line[0] : 1'b1;
    check_eq("tx",      tx[sel],   exp_tx);
    check_eq("thre",    thre[sel], !hold_v);
    check_eq("busy",    busy[sel], line.size() > 0);
    check_eq("overrun", ovr[sel],  exp_ovr);
  endtask

  task automatic step(input bit ld, input logic [7:0] d);
    @(negedge clk);
    load_bar[sel] = ~ld;
    d_in = d;
    @(posedge clk);
    cycle++;
    model_edge(ld, d);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, ".tx"},      tx[k],   1'b1);
      check_eq({tag, ".thre"},    thre[k], 1'b1);
      check_eq({tag, ".busy"},    busy[k], 1'b0);
      check_eq({tag, ".overrun"}, ovr[k],  1'b0);
    end
  endtask

  // Asserts Clear_bar between clock edges and checks the outputs react
  // without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    load_bar = 2'b11;
    #2 clear_bar = 1'b0;
    #1 check_reset_state("rst_async");
    repeat (2) @(posedge clk);
    #1 check_reset_state("rst_held");
    @(negedge clk);
    clear_bar = 1'b1;
    model_reset();
    $display("cycle %0d reset released", cycle);
  endtask

  initial begin
    bit found;
    clear_bar = 1'b0;
    load_bar  = 2'b11;
    d_in      = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_state("por");
    @(negedge clk);
    clear_bar = 1'b1;

    // ---- instance A: DIVISOR=4, one stop bit ----
    sel = 0;
    repeat (3) step(1'b0, 8'h00);

    step(1'b1, 8'hA5);                       // single frame
    repeat (45) step(1'b0, 8'h00);

    step(1'b1, 8'h01);                       // back-to-back
    repeat (10) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    repeat (90) step(1'b0, 8'h00);

    step(1'b1, 8'h11);                       // overrun on third write
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    check_eq("ovr.third_pulse", ovr[0], 1'b1);
    step(1'b0, 8'h00);
    check_eq("ovr.one_cycle", ovr[0], 1'b0);
    repeat (90) step(1'b0, 8'h00);

    step(1'b1, 8'h44);                       // load on the transfer edge
    repeat (5) step(1'b0, 8'h00);
    step(1'b1, 8'h55);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (line.size() == 1 && hold_v) found = 1'b1;
      else step(1'b0, 8'h00);
    end
    check_eq("simul.reached", found, 1'b1);
    step(1'b1, 8'h66);
    check_eq("simul.accepted", last_acc, 1'b1);
    check_eq("simul.no_ovr", ovr[0], 1'b0);
    check_eq("simul.thre_low", thre[0], 1'b0);
    repeat (100) step(1'b0, 8'h00);

    step(1'b1, 8'hC3);                       // reset mid-frame
    repeat (15) step(1'b0, 8'h00);
    do_reset();
    repeat (20) step(1'b0, 8'h00);

    repeat (600) step($urandom_range(0, 99) < 8, 8'($urandom));
    repeat (100) step(1'b0, 8'h00);

    // ---- instance B: DIVISOR=3, two stop bits ----
    do_reset();
    sel = 1;
    step(1'b1, 8'h00);
    repeat (40) step(1'b0, 8'h00);
    repeat (400) step($urandom_range(0, 99) < 6, 8'($urandom));
    repeat (80) step(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_shifter.md
Name: uart_tx_shifter

Overview:
- Transmit-side serial converter for the SCAMP output port.
- The CPU writes a byte in parallel using the same active-low-enable load style as the octal latches.
- The block holds the byte in a one-entry holding register, moves it into a shift register, and sends it LSB-first as an asynchronous serial frame (start, data, stop).
- It is the drain/reader end of the CPU's parallel output write path.

Parameters:
- WIDTH, 8, data bits per frame.
- DIVISOR, 16, Clk cycles per serial bit time; legal range 2 to 65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- DELAY_RISE, 0, rise propagation delay applied to every output.
- DELAY_FALL, 0, fall propagation delay applied to every output.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Clear_bar  input  1  asynchronous, active-low reset.
- Load_bar  input  1  active-low write strobe; sampled on the rising edge of Clk.
- D  input  WIDTH  parallel data to transmit.
- Tx  output  1  serial line; idles high.
- Thre  output  1  high when the holding register is empty.
- Busy  output  1  high while a frame is on the line.
- Overrun  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Interface (decided): one clock, Clk. Reset is Clear_bar: asynchronous, active-low. Clear_bar low forces state immediately, independent of Clk.
- Reset values: Tx=1, Thre=1, Busy=0, Overrun=0, state=IDLE, all counters 0, hold and shift registers 0. Reset during a frame aborts it: Tx returns high at once and no partial frame resumes.
- Load rule: on an edge with Load_bar=0:
  - If hold is empty, or hold is being transferred to the shifter on that same edge: D is captured into hold and Thre=0 from that edge.
  - Otherwise hold is kept unchanged, the write is discarded, and Overrun=1 for exactly one cycle.
- States: IDLE, START, DATA, STOP.
- IDLE: Tx=1, Busy=0. On an edge with hold full: shift<=hold, Thre=1, state=START, bit timer=0, Tx=0 and Busy=1 from that edge.
  - Latency: a load at edge k with the block idle and hold empty gives the start bit at edge k+1.
- START: Tx=0 for DIVISOR cycles, then DATA with bit index 0.
- DATA: Tx=shift[0] for DIVISOR cycles per bit, then shift right by one. After bit WIDTH-1 completes, go to STOP.
- STOP: Tx=1 for STOP_BITS*DIVISOR cycles. On the final cycle:
  - If hold is full, transfer it directly to the shifter and go to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- Frame length is DIVISOR*(1+WIDTH+STOP_BITS) cycles, measured from the first Tx-low edge to the first edge of the next start bit in back-to-back operation.
- Bit timer: counts 0 to DIVISOR-1 and wraps. A bit boundary occurs at the wrap. The timer is reset to 0 on every IDLE-to-START transition.
- Width rules:
  - Bit timer width is clog2(DIVISOR).
  - Bit index width is clog2(WIDTH)+1.
  - Stop counter width is 2.
  - No arithmetic overflow is permitted.
- Tx is driven from a register, so it is glitch-free.
- All outputs pass through the parameterised rise/fall delay.

Decomposition:
- Shared header uart_defs.vh holds:
  - State encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - The TX idle level constant.
  - The same header will later serve the receive-side block.
- One sub-module, uart_bit_timer:
  - DIVISOR-parameterised counter with sync restart input, async Clear_bar, and a one-cycle Tick output at wrap.
- Hold register, shifter and FSM live in the top module.

Test Plan:
- Reset: hold Clear_bar low mid-frame with WIDTH=8, DIVISOR=4 → Tx=1, Thre=1, Busy=0 immediately. After release the line stays idle with no residual bits.
- Single frame: DIVISOR=4, load 8'hA5 at edge k.
  - Tx low at edges k+1..k+4.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Then high for 4 cycles.
  - Busy falls at edge k+41. Thre=0 only at edge k.
- Back-to-back: load 8'h01, then load 8'hFF while the first is shifting → second start bit begins immediately after the first stop bit with zero idle cycles, and Thre goes high at the transfer.
- Overrun: load 8'h11, 8'h22, 8'h33 on consecutive cycles while busy → 8'h11 and 8'h22 are transmitted, 8'h33 is dropped, and Overrun pulses for exactly 1 cycle on the third load.
- Simultaneous transfer and load: issue a load on the exact edge of the STOP-to-START transfer → the new byte is accepted, Overrun stays 0, and Thre stays 0.
- STOP_BITS=2, DIVISOR=3, load 8'h00 → start bit plus eight 0 bits (27 cycles low), then 6 cycles high before Busy falls.
